// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the parametrised register file.
// Optional same-edge write bypass is enabled with `define REG_FILE_BYPASS_EN.
package reg_file_pkg;

    typedef logic [1:0] clr_state_t;

    localparam clr_state_t ST_IDLE  = 2'd0;
    localparam clr_state_t ST_CLEAR = 2'd1;
    localparam clr_state_t ST_DONE  = 2'd2;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 2;
    localparam int DEF_NRD    = 2;

    function automatic logic [7:0] merge_byte(
        input logic [7:0] old_b,
        input logic [7:0] new_b,
        input logic       en
    );
        return en ? new_b : old_b;
    endfunction

endpackage

// File: rtl/reg_file_if.sv
// Write, read and clear signals of the register file.
// master drives requests, slave (the register file) answers them.
interface reg_file_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2,
    parameter int NRD    = 2
);

    logic                   wr_en;
    logic [ADDR_W-1:0]      w_addr;
    logic [DATA_W/8-1:0]    w_be;
    logic [DATA_W-1:0]      w_data;
    logic                   wr_ready;
    logic [NRD*ADDR_W-1:0]  r_addr;
    logic [NRD*DATA_W-1:0]  r_data;
    logic                   clr_req;
    logic                   clr_busy;
    logic                   clr_done;

    modport master (
        output wr_en, w_addr, w_be, w_data,
        output r_addr, clr_req,
        input  wr_ready, r_data, clr_busy, clr_done
    );

    modport slave (
        input  wr_en, w_addr, w_be, w_data,
        input  r_addr, clr_req,
        output wr_ready, r_data, clr_busy, clr_done
    );

endinterface

// File: rtl/reg_file_clr_fsm.sv
// Bulk-clear sequencer: sweeps every address once, then pulses done.
// Built the same way with or without REG_FILE_BYPASS_EN.
module reg_file_clr_fsm
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_idx
);

    localparam logic [ADDR_W-1:0] LAST = '1;

    clr_state_t state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            clr_idx <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (clr_req) begin
                        state   <= ST_CLEAR;
                        clr_idx <= '0;
                    end
                end
                ST_CLEAR: begin
                    clr_idx <= clr_idx + ADDR_W'(1);
                    if (clr_idx == LAST)
                        state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign clr_busy = (state == ST_CLEAR);
    assign clr_done = (state == ST_DONE);
    assign clr_we   = clr_busy;

endmodule

// File: rtl/reg_file_param.sv
// DEPTH x DATA_W register file: one byte-masked write port, NRD registered reads,
// optional hardwired-zero R0, bulk clear. `define REG_FILE_BYPASS_EN for write bypass.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int NRD     = DEF_NRD,
    parameter int ZERO_R0 = 0
) (
    input logic        clk,
    input logic        rst,
    reg_file_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_busy;
    logic              clr_done;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_idx;

    logic              wr_block;
    logic              wr_fire;
    logic [DATA_W-1:0] wr_old;
    logic [DATA_W-1:0] wr_word;
    logic [DATA_W-1:0] rd_q_arr [NRD];

    reg_file_clr_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clr (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (bus.clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .clr_we   (clr_we),
        .clr_idx  (clr_idx)
    );

    assign bus.wr_ready = ~clr_busy;
    assign bus.clr_busy = clr_busy;
    assign bus.clr_done = clr_done;

    // R0 writes are squashed here so neither storage nor bypass sees them
    assign wr_block = (ZERO_R0 != 0) && (bus.w_addr == '0);
    assign wr_fire  = bus.wr_en & ~clr_busy & ~wr_block;
    assign wr_old   = mem[bus.w_addr];

    always_comb begin
        wr_word = '0;
        for (int i = 0; i < NB; i++)
            wr_word[8*i +: 8] = merge_byte(wr_old[8*i +: 8],
                                           bus.w_data[8*i +: 8],
                                           bus.w_be[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (clr_we) begin
            mem[clr_idx] <= '0;
        end else if (wr_fire) begin
            mem[bus.w_addr] <= wr_word;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd_next;
        logic [DATA_W-1:0] rd_q;

        assign ra = bus.r_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            rd_next = mem[ra];
`ifdef REG_FILE_BYPASS_EN
            if (wr_fire && (ra == bus.w_addr))
                rd_next = wr_word;
`endif
            if ((ZERO_R0 != 0) && (ra == '0))
                rd_next = '0;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                rd_q <= '0;
            else
                rd_q <= rd_next;
        end

        assign rd_q_arr[k] = rd_q;
    end

    always_comb begin
        bus.r_data = '0;
        for (int k = 0; k < NRD; k++)
            bus.r_data[k*DATA_W +: DATA_W] = rd_q_arr[k];
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: table vectors plus clear/reset/R0 sequences.
// Expected same-edge read values follow REG_FILE_BYPASS_EN when it is defined.
module tb_reg_file_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    reg_file_if #(.DATA_W(16), .ADDR_W(2), .NRD(2)) bus ();
    reg_file_if #(.DATA_W(16), .ADDR_W(2), .NRD(2)) bus_z ();

    reg_file_param #(
        .DATA_W(16), .ADDR_W(2), .NRD(2), .ZERO_R0(0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    reg_file_param #(
        .DATA_W(16), .ADDR_W(2), .NRD(2), .ZERO_R0(1)
    ) dut_z (
        .clk (clk),
        .rst (rst),
        .bus (bus_z.slave)
    );

    typedef struct {
        logic        we;
        logic [1:0]  wa;
        logic [1:0]  be;
        logic [15:0] wd;
        logic [1:0]  ra0;
        logic [1:0]  ra1;
        logic [15:0] e0;
        logic [15:0] e1;
    } vec_t;

    vec_t tv [11];

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic en, input logic [1:0] a,
                          input logic [1:0] be, input logic [15:0] d);
        bus.wr_en  = en;
        bus.w_addr = a;
        bus.w_be   = be;
        bus.w_data = d;
    endtask

    task automatic set_rd(input logic [1:0] a0, input logic [1:0] a1);
        bus.r_addr = {a1, a0};
    endtask

    function automatic logic [15:0] rd0();
        return bus.r_data[15:0];
    endfunction

    function automatic logic [15:0] rd1();
        return bus.r_data[31:16];
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_byp;

        tv[0]  = '{1'b1, 2'd0, 2'b11, 16'hAAAA, 2'd1, 2'd2, 16'h0000, 16'h0000};
        tv[1]  = '{1'b1, 2'd1, 2'b11, 16'h5555, 2'd0, 2'd3, 16'hAAAA, 16'h0000};
        tv[2]  = '{1'b1, 2'd2, 2'b11, 16'h1234, 2'd1, 2'd0, 16'h5555, 16'hAAAA};
        tv[3]  = '{1'b1, 2'd3, 2'b11, 16'hFFFF, 2'd2, 2'd2, 16'h1234, 16'h1234};
        tv[4]  = '{1'b0, 2'd0, 2'b00, 16'h0000, 2'd0, 2'd3, 16'hAAAA, 16'hFFFF};
        tv[5]  = '{1'b1, 2'd1, 2'b01, 16'h12AB, 2'd3, 2'd0, 16'hFFFF, 16'hAAAA};
        tv[6]  = '{1'b0, 2'd0, 2'b00, 16'h0000, 2'd1, 2'd1, 16'h55AB, 16'h55AB};
        tv[7]  = '{1'b1, 2'd3, 2'b10, 16'hEE00, 2'd1, 2'd2, 16'h55AB, 16'h1234};
        tv[8]  = '{1'b0, 2'd0, 2'b11, 16'h0000, 2'd3, 2'd0, 16'hEEFF, 16'hAAAA};
        tv[9]  = '{1'b1, 2'd0, 2'b00, 16'h0000, 2'd0, 2'd1, 16'hAAAA, 16'h55AB};
        tv[10] = '{1'b0, 2'd0, 2'b00, 16'h0000, 2'd0, 2'd3, 16'hAAAA, 16'hEEFF};

        set_wr(1'b0, 2'd0, 2'b00, 16'h0);
        set_rd(2'd0, 2'd0);
        bus.clr_req   = 1'b0;
        bus_z.wr_en   = 1'b0;
        bus_z.w_addr  = 2'd0;
        bus_z.w_be    = 2'b00;
        bus_z.w_data  = 16'h0;
        bus_z.r_addr  = 4'h0;
        bus_z.clr_req = 1'b0;

        #3;
        chk("rst_rd0", rd0(), 16'h0);
        chk("rst_rd1", rd1(), 16'h0);
        chk("rst_busy", {15'b0, bus.clr_busy}, 16'h0);
        chk("rst_done", {15'b0, bus.clr_done}, 16'h0);
        chk("rst_wr_ready", {15'b0, bus.wr_ready}, 16'h1);
        #9;
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            set_wr(tv[i].we, tv[i].wa, tv[i].be, tv[i].wd);
            set_rd(tv[i].ra0, tv[i].ra1);
            step();
            chk($sformatf("vec%0d_rd0", i), rd0(), tv[i].e0);
            chk($sformatf("vec%0d_rd1", i), rd1(), tv[i].e1);
        end

        // same-edge write/read of address 2
`ifdef REG_FILE_BYPASS_EN
        exp_byp = 16'h0BEE;
`else
        exp_byp = 16'h1234;
`endif
        set_wr(1'b1, 2'd2, 2'b11, 16'h0BEE);
        set_rd(2'd2, 2'd2);
        step();
        chk("byp_same_edge", rd0(), exp_byp);
        set_wr(1'b0, 2'd0, 2'b00, 16'h0);
        step();
        chk("byp_next", rd1(), 16'h0BEE);

        // bulk clear with a write attempted while busy
        bus.clr_req = 1'b1;
        step();
        bus.clr_req = 1'b0;
        set_wr(1'b1, 2'd0, 2'b11, 16'h7777);
        set_rd(2'd0, 2'd3);
        chk("clr_e0_busy", {15'b0, bus.clr_busy}, 16'h1);
        chk("clr_e0_wr_ready", {15'b0, bus.wr_ready}, 16'h0);
        step();
        chk("clr_e1_busy", {15'b0, bus.clr_busy}, 16'h1);
        chk("clr_e1_done", {15'b0, bus.clr_done}, 16'h0);
        step();
        chk("clr_e2_busy", {15'b0, bus.clr_busy}, 16'h1);
        chk("clr_e2_rd_cleared", rd0(), 16'h0);
        chk("clr_e2_rd_old", rd1(), 16'hEEFF);
        step();
        chk("clr_e3_busy", {15'b0, bus.clr_busy}, 16'h1);
        set_wr(1'b0, 2'd0, 2'b00, 16'h0);
        step();
        chk("clr_e4_busy", {15'b0, bus.clr_busy}, 16'h0);
        chk("clr_e4_done", {15'b0, bus.clr_done}, 16'h1);
        chk("clr_e4_wr_ready", {15'b0, bus.wr_ready}, 16'h1);
        step();
        chk("clr_e5_done", {15'b0, bus.clr_done}, 16'h0);
        chk("clr_e5_busy", {15'b0, bus.clr_busy}, 16'h0);
        set_rd(2'd0, 2'd1);
        step();
        chk("clr_mem0", rd0(), 16'h0);
        chk("clr_mem1", rd1(), 16'h0);
        set_rd(2'd2, 2'd3);
        step();
        chk("clr_mem2", rd0(), 16'h0);
        chk("clr_mem3", rd1(), 16'h0);

        // asynchronous reset with clr_idx at 2
        set_wr(1'b1, 2'd1, 2'b11, 16'h4321);
        step();
        set_wr(1'b0, 2'd0, 2'b00, 16'h0);
        bus.clr_req = 1'b1;
        step();
        bus.clr_req = 1'b0;
        set_rd(2'd1, 2'd1);
        step();
        step();
        chk("mid_clr_busy", {15'b0, bus.clr_busy}, 16'h1);
        chk("mid_clr_rd", rd0(), 16'h4321);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_rd0", rd0(), 16'h0);
        chk("arst_rd1", rd1(), 16'h0);
        chk("arst_busy", {15'b0, bus.clr_busy}, 16'h0);
        chk("arst_done", {15'b0, bus.clr_done}, 16'h0);
        #2;
        rst = 1'b0;
        step();
        chk("post_rst_busy", {15'b0, bus.clr_busy}, 16'h0);
        chk("post_rst_wr_ready", {15'b0, bus.wr_ready}, 16'h1);
        set_wr(1'b1, 2'd2, 2'b11, 16'h1111);
        set_rd(2'd1, 2'd3);
        step();
        chk("post_rst_mem1", rd0(), 16'h0);
        chk("post_rst_mem3", rd1(), 16'h0);
        set_wr(1'b0, 2'd0, 2'b00, 16'h0);
        set_rd(2'd2, 2'd2);
        step();
        chk("post_rst_write", rd0(), 16'h1111);

        // hardwired-zero R0 instance
        bus_z.wr_en  = 1'b1;
        bus_z.w_addr = 2'd0;
        bus_z.w_be   = 2'b11;
        bus_z.w_data = 16'hFFFF;
        bus_z.r_addr = {2'd0, 2'd0};
        step();
        chk("z_same_edge", bus_z.r_data[15:0], 16'h0);
        bus_z.w_addr = 2'd1;
        bus_z.w_data = 16'h5A5A;
        bus_z.r_addr = {2'd2, 2'd0};
        step();
        chk("z_r0_after_wr", bus_z.r_data[15:0], 16'h0);
        chk("z_mem2", bus_z.r_data[31:16], 16'h0);
        bus_z.wr_en  = 1'b0;
        bus_z.r_addr = {2'd1, 2'd0};
        step();
        chk("z_r0_read", bus_z.r_data[15:0], 16'h0);
        chk("z_mem1", bus_z.r_data[31:16], 16'h5A5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
